// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel between NUM_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to hold a grant until the byte flagged req_last is accepted.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         init_done,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int GW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rrPtr_q, rrPtr_d;
    logic [7:0]    gapCnt_q, gapCnt_d;
    logic          initSticky_q, initSticky_d;

    logic [GW-1:0] winner;
    logic          found;
    logic          handshake;

`ifndef UART_ARB_PKT_LOCK_EN
    logic unusedLast;
    assign unusedLast = ^req_last;
`endif

    // Search starts just after the last granted requester so it ends up lowest priority.
    always_comb begin
        winner = rrPtr_q;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rrPtr_q) + k) % NUM_REQ]) begin
                winner = GW'((int'(rrPtr_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        if (state_q == SEND) begin
            tx_valid           = req_valid[grant_q];
            tx_data            = req_data[int'(grant_q) * DATA_W +: DATA_W];
            req_ready[grant_q] = tx_ready;
        end
    end

    assign handshake = tx_valid && tx_ready;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rrPtr_d      = rrPtr_q;
        gapCnt_d     = gapCnt_q;
        initSticky_d = initSticky_q | init_done;
        case (state_q)
            IDLE: begin
                if (enable && initSticky_q && found) begin
                    grant_d = winner;
                    state_d = SEND;
                end
            end
            SEND: begin
`ifdef UART_ARB_PKT_LOCK_EN
                // Stay on the line until the packet's final byte is taken, even if valid drops.
                if (handshake && req_last[grant_q]) begin
`else
                if (handshake) begin
`endif
                    rrPtr_d = grant_q;
                    if (IDLE_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = GAP;
                        gapCnt_d = 8'(IDLE_GAP - 1);
                    end
`ifndef UART_ARB_PKT_LOCK_EN
                end else if (!req_valid[grant_q]) begin
                    state_d = IDLE;
`endif
                end
            end
            GAP: begin
                if (gapCnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rrPtr_q      <= GW'(NUM_REQ - 1);
            gapCnt_q     <= 8'd0;
            initSticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rrPtr_q      <= rrPtr_d;
            gapCnt_q     <= gapCnt_d;
            initSticky_q <= initSticky_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a zero-gap instance and a three-cycle-gap instance
// share clock, reset, enable and init_done.
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        init_done = 1'b0;

    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_last = 2'b11;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [0:0]  grant_id;
    logic        busy;

    logic [1:0]  req_valid3 = 2'b00;
    logic [15:0] req_data3 = 16'h0000;
    logic [1:0]  req_last3 = 2'b11;
    logic [1:0]  req_ready3;
    logic        tx_valid3;
    logic [7:0]  tx_data3;
    logic        tx_ready3 = 1'b0;
    logic [0:0]  grant_id3;
    logic        busy3;

    int testCount = 0;
    int failCount = 0;

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .IDLE_GAP(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .init_done(init_done),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .IDLE_GAP(3)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .init_done(init_done),
        .req_valid(req_valid3), .req_data(req_data3), .req_last(req_last3),
        .req_ready(req_ready3), .tx_valid(tx_valid3), .tx_data(tx_data3),
        .tx_ready(tx_ready3), .grant_id(grant_id3), .busy(busy3)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] data,
                                 input logic ready);
        req_valid = valid;
        req_data  = data;
        tx_ready  = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] recBytes [5];
        logic [7:0] expBytes [5];
        int         nRec;
        int         expN;
        int         idx0;
        logic       adv0;
        logic       sawActivity;
        int         hsCyc [8];
        int         nHs;
        logic       gapBusy;
        logic       gapValid;

        step();
        step();
        @(negedge clock);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;

        // Single requester: one cycle of arbitration, then one accepted byte.
        init_done = 1'b1;
        enable    = 1'b1;
        step();
        init_done = 1'b0;
        applyStimulus(2'b01, 16'h0041, 1'b1);
        @(negedge clock);
        checkOutput("single_arb_cycle_tx_valid", 32'(tx_valid), 32'd0);
        step();
        @(negedge clock);
        checkOutput("single_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("single_tx_data", 32'(tx_data), 32'h41);
        checkOutput("single_grant_id", 32'(grant_id), 32'd0);
        checkOutput("single_req_ready", 32'(req_ready), 32'b01);
        checkOutput("single_busy", 32'(busy), 32'd1);
        step();
        req_valid = 2'b00;
        @(negedge clock);
        checkOutput("single_req_ready_after", 32'(req_ready), 32'b00);
        checkOutput("single_busy_after", 32'(busy), 32'd0);

        // Both valid: last grant was 0, so requester 1 leads and they alternate.
        applyStimulus(2'b11, 16'hB1A0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clock);
            checkOutput("alt_tx_valid", 32'(tx_valid), 32'd1);
            checkOutput("alt_tx_data", 32'(tx_data), (i % 2 == 0) ? 32'hB1 : 32'hA0);
            checkOutput("alt_grant_id", 32'(grant_id), (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
            @(negedge clock);
            checkOutput("alt_idle_between", 32'(busy), 32'd0);
        end

        // Requester 1 stalled by tx_ready=0, then reset mid-SEND.
        applyStimulus(2'b10, 16'hB1A0, 1'b0);
        step();
        @(negedge clock);
        checkOutput("stall_grant_id", 32'(grant_id), 32'd1);
        checkOutput("stall_tx_data", 32'(tx_data), 32'hB1);
        checkOutput("stall_req_ready", 32'(req_ready), 32'b00);
        repeat (10) step();
        @(negedge clock);
        checkOutput("stall_hold_busy", 32'(busy), 32'd1);
        checkOutput("stall_hold_tx_valid", 32'(tx_valid), 32'd1);
        step();
        reset = 1'b1;
        step();
        @(negedge clock);
        checkOutput("midsend_rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("midsend_rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("midsend_rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;

        // No init_done since reset: requests must be ignored.
        applyStimulus(2'b11, 16'hB1A0, 1'b0);
        sawActivity = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (tx_valid !== 1'b0 || busy !== 1'b0) sawActivity = 1'b1;
            step();
        end
        checkOutput("no_init_activity", 32'(sawActivity), 32'd0);

        init_done = 1'b1;
        step();
        init_done = 1'b0;
        @(negedge clock);
        checkOutput("post_init_arb_busy", 32'(busy), 32'd0);
        step();
        @(negedge clock);
        checkOutput("post_rst_first_grant", 32'(grant_id), 32'd0);
        checkOutput("post_rst_tx_data", 32'(tx_data), 32'hA0);
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'b00);

        // Requester 0 withdraws before acceptance.
        req_valid = 2'b00;
        @(negedge clock);
        checkOutput("drop_tx_valid", 32'(tx_valid), 32'd0);
        step();
`ifdef UART_ARB_PKT_LOCK_EN
        applyStimulus(2'b01, 16'hB1A0, 1'b1);
        @(negedge clock);
        checkOutput("drop_locked_busy", 32'(busy), 32'd1);
        checkOutput("drop_locked_grant", 32'(grant_id), 32'd0);
        checkOutput("drop_locked_tx_valid", 32'(tx_valid), 32'd1);
        step();
`else
        applyStimulus(2'b11, 16'hB1A0, 1'b1);
        @(negedge clock);
        checkOutput("drop_back_idle", 32'(busy), 32'd0);
        step();
        @(negedge clock);
        checkOutput("drop_rr_unchanged_grant", 32'(grant_id), 32'd0);
        checkOutput("drop_regrant_tx_valid", 32'(tx_valid), 32'd1);
        step();
`endif

        // Give requester 1 one byte so requester 0 leads the packet test.
        applyStimulus(2'b10, 16'h20A0, 1'b1);
        step();
        @(negedge clock);
        checkOutput("pre_pkt_grant", 32'(grant_id), 32'd1);
        step();

`ifdef UART_ARB_PKT_LOCK_EN
        expN = 4;
        expBytes = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h00};
`else
        expN = 5;
        expBytes = '{8'h10, 8'h20, 8'h11, 8'h20, 8'h12};
`endif
        recBytes = '{default: 8'h00};
        nRec = 0;
        idx0 = 0;
        req_last = 2'b10;
        applyStimulus(2'b11, 16'h2010, 1'b1);
        for (int c = 0; c < 30 && nRec < expN; c++) begin
            @(negedge clock);
            if (tx_valid && tx_ready) begin
                recBytes[nRec] = tx_data;
                nRec++;
            end
            adv0 = req_ready[0];
            step();
            if (adv0) begin
                idx0++;
                if (idx0 == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_data[7:0] = 8'(8'h10 + idx0);
                    req_last[0]   = (idx0 == 2);
                end
            end
        end
        checkOutput("pkt_byte_count", 32'(nRec), 32'(expN));
        for (int i = 0; i < expN; i++) begin
            checkOutput("pkt_byte_order", 32'(recBytes[i]), 32'(expBytes[i]));
        end
        req_valid = 2'b00;
        req_last  = 2'b11;
        step();
        step();

        // Gap instance: a lone always-valid requester is accepted every five cycles.
        req_valid3 = 2'b01;
        req_data3  = 16'h0055;
        tx_ready3  = 1'b1;
        nHs = 0;
        gapBusy = 1'b0;
        gapValid = 1'b1;
        hsCyc = '{default: 0};
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (tx_valid3 && tx_ready3 && nHs < 8) begin
                hsCyc[nHs] = c;
                nHs++;
            end
            if (c == 3) begin
                gapBusy  = busy3;
                gapValid = tx_valid3;
            end
            step();
        end
        checkOutput("gap_handshake_count", 32'(nHs), 32'd5);
        checkOutput("gap_first_handshake", 32'(hsCyc[0]), 32'd1);
        checkOutput("gap_spacing_1", 32'(hsCyc[1] - hsCyc[0]), 32'd5);
        checkOutput("gap_spacing_2", 32'(hsCyc[2] - hsCyc[1]), 32'd5);
        checkOutput("gap_busy_in_gap", 32'(gapBusy), 32'd1);
        checkOutput("gap_tx_valid_in_gap", 32'(gapValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
